// File: rtl/packet_dispatcher.sv
// Packet dispatcher: pops one packet at a time from the upstream queue and
// presents it to one of NUM_PORTS server ports over a one-hot valid/ready bus.
module packet_dispatcher #(
   parameter int unsigned NUM_PORTS = 8,
   parameter int unsigned PAYLOAD_W = 128,
   parameter int unsigned ID_W      = 32,
   parameter int unsigned ADDR_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 q_empty,
   output logic                 q_pop,
   input  logic [ID_W-1:0]      q_id,
   input  logic [ADDR_W-1:0]    q_src,
   input  logic [ADDR_W-1:0]    q_dest,
   input  logic [PAYLOAD_W-1:0] q_payload,
   output logic [NUM_PORTS-1:0] out_valid,
   input  logic [NUM_PORTS-1:0] out_ready,
   output logic [ID_W-1:0]      out_id,
   output logic [ADDR_W-1:0]    out_src,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic                 busy,
   output logic [31:0]          sent_count,
   output logic [15:0]          drop_count
);

   localparam int unsigned        CMP_W      = ADDR_W + 1;
   localparam logic [CMP_W-1:0]   PORT_LIMIT = CMP_W'(NUM_PORTS);
   localparam logic [15:0]        DROP_MAX   = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_SEND,
      S_DROP
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 pop_nxt;
   logic                 busy_nxt;
   logic [NUM_PORTS-1:0] valid_nxt;
   logic                 dest_ok;
   logic                 send_done;
   logic [NUM_PORTS-1:0] dest_sel;

   // Extra compare bit keeps the range check correct when NUM_PORTS == 2**ADDR_W.
   assign dest_ok   = CMP_W'(q_dest) < PORT_LIMIT;
   assign dest_sel  = NUM_PORTS'(1) << q_dest;
   // out_valid is one-hot, so only the selected port's ready can complete a transfer.
   assign send_done = |(out_valid & out_ready);

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         q_pop     <= 1'b0;
         busy      <= 1'b0;
         out_valid <= '0;
      end else begin
         state     <= state_nxt;
         q_pop     <= pop_nxt;
         busy      <= busy_nxt;
         out_valid <= valid_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt = state;
      valid_nxt = '0;
      pop_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (en && !q_empty) state_nxt = S_POP;
         end
         S_POP: begin
            state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (dest_ok) begin
               state_nxt = S_SEND;
               valid_nxt = dest_sel;
            end else begin
               state_nxt = S_DROP;
            end
         end
         S_SEND: begin
            if (send_done) state_nxt = S_IDLE;
            else           valid_nxt = out_valid;
         end
         S_DROP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      pop_nxt  = (state_nxt == S_POP);
      busy_nxt = (state_nxt != S_IDLE);
   end

   // Packet hold registers; they keep the last packet after delivery.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_id      <= '0;
         out_src     <= '0;
         out_payload <= '0;
      end else if (state == S_LOAD) begin
         out_id      <= q_id;
         out_src     <= q_src;
         out_payload <= q_payload;
      end
   end

   // Delivery and drop statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         sent_count <= '0;
         drop_count <= '0;
      end else begin
         if ((state == S_SEND) && send_done) sent_count <= sent_count + 32'd1;
         if ((state == S_DROP) && (drop_count != DROP_MAX)) drop_count <= drop_count + 16'd1;
      end
   end

endmodule
